maquina_estados: RTL and testbench

Top-level control FSM for the four-port FIFO/arbiter datapath. It sequences the datapath through RESET, INIT, IDLE, ACTIVE and ERROR, drives the 4-bit `state` bus consumed by the arbiters, and latches the FIFO almost-full/almost-empty thresholds loaded during INIT. It monitors FIFO error flags and an almost-full stall watchdog, and parks the datapath in ERROR until the next reset.

---
 rtl/maquina_estados.sv | 146 ++++++++++++++
 tb/tb_maquina_estados.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/maquina_estados.sv
// Top-level control FSM for the four-port FIFO/arbiter datapath: sequences RESET/INIT/IDLE/ACTIVE/ERROR,
// commits the almost-full/almost-empty thresholds and traps FIFO faults and almost-full stalls.
module maquina_estados #(
    parameter int UMBRAL_W  = 4,
    parameter int STALL_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [UMBRAL_W-1:0] umbral_alto_in,
    input  logic [UMBRAL_W-1:0] umbral_bajo_in,
    input  logic [7:0]          empties,
    input  logic [3:0]          almost_full,
    input  logic [7:0]          fifo_error,
    output logic [3:0]          state,
    output logic [UMBRAL_W-1:0] umbral_alto_out,
    output logic [UMBRAL_W-1:0] umbral_bajo_out,
    output logic                idle_out,
    output logic                error_out,
    output logic [7:0]          error_fifo,
    output logic                stall_error,
    output logic                cfg_error
);

    localparam int CNT_W = $clog2(STALL_MAX + 1);

    localparam logic [3:0] ST_RESET  = 4'd0;
    localparam logic [3:0] ST_INIT   = 4'd1;
    localparam logic [3:0] ST_IDLE   = 4'd2;
    localparam logic [3:0] ST_ACTIVE = 4'd3;
    localparam logic [3:0] ST_ERROR  = 4'd4;

    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    next_stall_cnt;
    logic [3:0]          next_state;
    logic [UMBRAL_W-1:0] next_umbral_alto;
    logic [UMBRAL_W-1:0] next_umbral_bajo;
    logic [7:0]          next_error_fifo;
    logic                next_stall_error;
    logic                next_cfg_error;

    logic stalling;
    logic fifo_fault;
    logic thr_valid;
    logic stall_trip;

    assign stalling   = |almost_full;
    assign fifo_fault = |fifo_error;
    assign thr_valid  = (umbral_bajo_in < umbral_alto_in);
    // The trip fires on the STALL_MAX-th consecutive stalled ACTIVE cycle.
    assign stall_trip = (state == ST_ACTIVE) && stalling && (stall_cnt == STALL_LAST);

    always_comb begin
        next_state       = state;
        next_umbral_alto = umbral_alto_out;
        next_umbral_bajo = umbral_bajo_out;
        next_error_fifo  = error_fifo;
        next_stall_error = stall_error;
        next_cfg_error   = cfg_error;

        case (state)
            ST_RESET: begin
                next_state = ST_INIT;
            end
            ST_INIT: begin
                if (fifo_fault) begin
                    next_state      = ST_ERROR;
                    next_error_fifo = fifo_error;
                end else if (init) begin
                    next_state = ST_INIT;
                end else if (thr_valid) begin
                    next_state       = ST_IDLE;
                    next_umbral_alto = umbral_alto_in;
                    next_umbral_bajo = umbral_bajo_in;
                end else begin
                    next_state     = ST_ERROR;
                    next_cfg_error = 1'b1;
                end
            end
            ST_IDLE: begin
                if (fifo_fault) begin
                    next_state      = ST_ERROR;
                    next_error_fifo = fifo_error;
                end else if (init) begin
                    next_state = ST_INIT;
                end else if (empties != 8'hFF) begin
                    next_state = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (fifo_fault) begin
                    next_state      = ST_ERROR;
                    next_error_fifo = fifo_error;
                end else if (init) begin
                    next_state = ST_INIT;
                end else if (stall_trip) begin
                    next_state       = ST_ERROR;
                    next_stall_error = 1'b1;
                end else if (empties == 8'hFF) begin
                    next_state = ST_IDLE;
                end
            end
            ST_ERROR: begin
                next_state = ST_ERROR;
            end
            default: begin
                next_state = ST_RESET;
            end
        endcase

        // Counting only while staying in ACTIVE makes every exit clear the watchdog.
        if ((state == ST_ACTIVE) && (next_state == ST_ACTIVE) && stalling) begin
            next_stall_cnt = stall_cnt + CNT_ONE;
        end else begin
            next_stall_cnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_RESET;
            umbral_alto_out <= '0;
            umbral_bajo_out <= '0;
            idle_out        <= 1'b0;
            error_out       <= 1'b0;
            error_fifo      <= 8'h00;
            stall_error     <= 1'b0;
            cfg_error       <= 1'b0;
            stall_cnt       <= '0;
        end else begin
            state           <= next_state;
            umbral_alto_out <= next_umbral_alto;
            umbral_bajo_out <= next_umbral_bajo;
            idle_out        <= (next_state == ST_IDLE);
            error_out       <= (next_state == ST_ERROR);
            error_fifo      <= next_error_fifo;
            stall_error     <= next_stall_error;
            cfg_error       <= next_cfg_error;
            stall_cnt       <= next_stall_cnt;
        end
    end

endmodule

// File: tb/tb_maquina_estados.sv
// Scoreboarded bench for maquina_estados: directed test-plan sequences followed by random traffic,
// checked every cycle against a behavioural model of the state rules.
module tb_maquina_estados;

    localparam int UW        = 4;
    localparam int STALL_MAX = 16;
    localparam int VW        = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [UW-1:0] umbral_alto_in;
    logic [UW-1:0] umbral_bajo_in;
    logic [7:0]    empties;
    logic [3:0]    almost_full;
    logic [7:0]    fifo_error;
    logic [3:0]    state;
    logic [UW-1:0] umbral_alto_out;
    logic [UW-1:0] umbral_bajo_out;
    logic          idle_out;
    logic          error_out;
    logic [7:0]    error_fifo;
    logic          stall_error;
    logic          cfg_error;

    maquina_estados #(.UMBRAL_W(UW), .STALL_MAX(STALL_MAX)) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_alto_in  (umbral_alto_in),
        .umbral_bajo_in  (umbral_bajo_in),
        .empties         (empties),
        .almost_full     (almost_full),
        .fifo_error      (fifo_error),
        .state           (state),
        .umbral_alto_out (umbral_alto_out),
        .umbral_bajo_out (umbral_bajo_out),
        .idle_out        (idle_out),
        .error_out       (error_out),
        .error_fifo      (error_fifo),
        .stall_error     (stall_error),
        .cfg_error       (cfg_error)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    // Scoreboard
    logic [VW-1:0] exp_q[$];
    string         tag_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    // Reference model: phase names as plain ints, stall tracked as a run length of stalled cycles
    int            m_phase;
    logic [UW-1:0] m_alto, m_bajo;
    logic [7:0]    m_efifo;
    logic          m_stall, m_cfg;
    int            m_run;

    function automatic logic [VW-1:0] pack(input int ph, input logic [UW-1:0] a, input logic [UW-1:0] b,
                                           input logic [7:0] ef, input logic st, input logic cf);
        logic [3:0] s4;
        s4 = 4'(ph);
        return {s4, a, b, (ph == 2), (ph == 4), ef, st, cf};
    endfunction

    task automatic model_step();
        int old_phase;
        old_phase = m_phase;
        if (reset) begin
            m_phase = 0; m_alto = '0; m_bajo = '0; m_efifo = 8'h00; m_stall = 1'b0; m_cfg = 1'b0; m_run = 0;
            return;
        end
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase != 4) begin
            if (fifo_error != 8'h00) begin
                m_phase = 4; m_efifo = fifo_error;
            end else if (init) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (int'(umbral_bajo_in) < int'(umbral_alto_in)) begin
                    m_phase = 2; m_alto = umbral_alto_in; m_bajo = umbral_bajo_in;
                end else begin
                    m_phase = 4; m_cfg = 1'b1;
                end
            end else if (m_phase == 2) begin
                if (empties != 8'hFF) m_phase = 3;
            end else begin
                if (almost_full != 4'h0 && m_run + 1 == STALL_MAX) begin
                    m_phase = 4; m_stall = 1'b1;
                end else if (empties == 8'hFF) begin
                    m_phase = 2;
                end
            end
        end
        if (old_phase == 3 && m_phase == 3 && almost_full != 4'h0) m_run = m_run + 1;
        else m_run = 0;
    endtask

    // Driver: inputs are set at the falling edge, the model advances and the expected result is queued
    task automatic tick(input string tag);
        model_step();
        exp_q.push_back(pack(m_phase, m_alto, m_bajo, m_efifo, m_stall, m_cfg));
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    task automatic set_in(input logic r, input logic i, input logic [UW-1:0] ua, input logic [UW-1:0] ub,
                          input logic [7:0] emp, input logic [3:0] af, input logic [7:0] fe);
        reset = r; init = i; umbral_alto_in = ua; umbral_bajo_in = ub;
        empties = emp; almost_full = af; fifo_error = fe;
    endtask

    task automatic ticks(input int n, input string tag);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    // Monitor: one registered output set per clock, compared just after the edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [VW-1:0] exp_v, act_v;
            string t;
            exp_v = exp_q.pop_front();
            t = tag_q.pop_front();
            act_v = {state, umbral_alto_out, umbral_bajo_out, idle_out, error_out, error_fifo, stall_error, cfg_error};
            n_checks++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL %s: got st=%0d alto=%0d bajo=%0d idle=%b err=%b efifo=%h stall=%b cfg=%b, expected st=%0d alto=%0d bajo=%0d idle=%b err=%b efifo=%h stall=%b cfg=%b",
                          t, act_v[23:20], act_v[19:16], act_v[15:12], act_v[11], act_v[10], act_v[9:2], act_v[1], act_v[0],
                          exp_v[23:20], exp_v[19:16], exp_v[15:12], exp_v[11], exp_v[10], exp_v[9:2], exp_v[1], exp_v[0]);
        end
    end

    // Brings the DUT from reset to ACTIVE with thresholds 6/2
    task automatic to_active(input string tag);
        set_in(1, 0, 6, 2, 8'hFF, 4'h0, 8'h00); tick({tag, "_rst"});
        reset = 0;                              ticks(2, {tag, "_boot"});
        empties = 8'hFE;                        tick({tag, "_act"});
    endtask

    logic [3:0] af_hold;

    initial begin
        m_phase = 0; m_alto = '0; m_bajo = '0; m_efifo = 8'h00; m_stall = 1'b0; m_cfg = 1'b0; m_run = 0;
        set_in(1, 0, 6, 2, 8'hFF, 4'h0, 8'h00);
        @(negedge clk);

        // Boot path and threshold commit
        ticks(2, "reset");
        reset = 0;               tick("boot_init");
        tick("boot_idle");

        // IDLE <-> ACTIVE on empties
        empties = 8'hFE;         ticks(3, "empties_active");
        empties = 8'hFF;         ticks(2, "empties_idle");

        // Invalid threshold pair while re-entering INIT
        set_in(0, 1, 5, 5, 8'hFF, 4'h0, 8'h00); ticks(2, "cfg_init");
        init = 0;                               tick("cfg_err");
        for (int k = 0; k < 4; k++) begin
            init = k[0]; empties = 8'h0F; almost_full = 4'hF; tick("cfg_absorb");
        end

        // Watchdog trips on the 16th stalled cycle
        to_active("wd");
        almost_full = 4'b0010;   ticks(STALL_MAX, "wd_trip");
        ticks(2, "wd_hold");

        // One gap cycle at cycle 10 keeps it alive
        to_active("gap");
        almost_full = 4'b0010;   ticks(9, "gap_pre");
        almost_full = 4'b0000;   tick("gap");
        almost_full = 4'b0010;   ticks(8, "gap_post");
        almost_full = 4'b0000;   tick("gap_clear");

        // FIFO error beats init
        fifo_error = 8'h20; init = 1; tick("fifo_err");
        fifo_error = 8'h00;           ticks(2, "fifo_err_hold");

        // Reset from ERROR and from ACTIVE
        reset = 1; init = 0;     tick("rst_from_err");
        to_active("ract");
        reset = 1;               tick("rst_from_active");
        reset = 0;

        // Random traffic
        af_hold = 4'h0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) af_hold = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            reset          = ($urandom_range(0, 59) == 0);
            init           = ($urandom_range(0, 24) == 0);
            umbral_alto_in = UW'($urandom_range(3, 15));
            umbral_bajo_in = UW'($urandom_range(0, 6));
            empties        = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            almost_full    = af_hold;
            fifo_error     = ($urandom_range(0, 99) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            tick("random");
        end

        set_in(0, 0, 0, 0, 8'hFF, 4'h0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
